mmio_peripheral_hub: RTL and testbench

Parametrised memory-mapped I/O hub between the processor data-memory port and board peripherals (push-buttons, servo PWM channels, audio tone). It decodes the 12-bit data address, captures button edges into clear-on-read sticky flags, holds per-channel servo duty registers with optional slew limiting, and holds the tone register. It returns read data with the same one-cycle latency as the data RAM, which it overrides for decoded addresses.

---
 rtl/mmio_peripheral_hub_if.sv | 14 +
 rtl/mmio_peripheral_hub.sv | 152 +++++++++++++++
 tb/tb_mmio_peripheral_hub.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_peripheral_hub_if.sv
// Data-memory side bus of the MMIO hub: address/write strobe/write data from the
// processor, RAM read data in, merged read data back to the processor.
interface mmio_peripheral_hub_if;
  logic [11:0] addr;
  logic        wren;
  logic [31:0] wdata;
  logic [31:0] ram_q;
  logic [31:0] rdata;

  // No valid/ready: every cycle is a transfer. Writes take effect on the edge
  // that samples wren; reads return data one cycle later, aligned with ram_q.
  modport master (output addr, output wren, output wdata, output ram_q, input rdata);
  modport slave  (input addr, input wren, input wdata, input ram_q, output rdata);
endinterface

// File: rtl/mmio_peripheral_hub.sv
// MMIO hub: sticky button edges, servo duty registers and tone register overlaid on the
// data RAM read path. Define HUB_SLEW_EN to make duty ramp toward target at a limited rate.
module mmio_peripheral_hub #(
  parameter int          NUM_BTN    = 6,
  parameter int          NUM_SERVO  = 3,
  parameter int          DUTY_W     = 10,
  parameter logic [11:0] BTN_BASE   = 12'd64,
  parameter logic [11:0] SERVO_BASE = 12'd80,
  parameter logic [11:0] TONE_ADDR  = 12'd96,
  parameter int          SLEW_DIV   = 50000,
  parameter int          SLEW_STEP  = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  mmio_peripheral_hub_if.slave          bus,
  input  logic [NUM_BTN-1:0]            btn,
  output logic [NUM_SERVO*DUTY_W-1:0]   duty,
  output logic [3:0]                    tone,
  output logic                          tone_en
);

  logic [NUM_BTN-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_BTN-1:0] btn_edge;
  logic [NUM_BTN-1:0] sticky_q, sticky_d;
  logic [NUM_BTN-1:0] clr;
  logic               hit_q, hit_d;
  logic [31:0]        rd_q, rd_d;
  logic [3:0]         tone_q, tone_d;
  logic               tone_en_q, tone_en_d;
  logic [DUTY_W-1:0]  target_q [NUM_SERVO];
  logic [DUTY_W-1:0]  target_d [NUM_SERVO];
  logic [DUTY_W-1:0]  duty_cur [NUM_SERVO];

  assign btn_edge = sync2_q & ~sync3_q;

  // Decode and read capture; a read clears the sticky flag but still reports
  // an edge arriving on the same cycle.
  always_comb begin
    hit_d     = 1'b0;
    rd_d      = '0;
    clr       = '0;
    tone_d    = tone_q;
    tone_en_d = tone_en_q;
    target_d  = target_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (bus.addr == BTN_BASE + 12'(i)) begin
        hit_d  = 1'b1;
        rd_d   = {31'b0, sticky_q[i] | btn_edge[i]};
        clr[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SERVO; i++) begin
      if (bus.addr == SERVO_BASE + 12'(i)) begin
        hit_d = 1'b1;
        rd_d  = 32'(duty_cur[i]);
        if (bus.wren) target_d[i] = bus.wdata[DUTY_W-1:0];
      end
    end
    if (bus.addr == TONE_ADDR) begin
      hit_d = 1'b1;
      rd_d  = {27'b0, tone_en_q, tone_q};
      if (bus.wren) begin
        tone_d    = bus.wdata[3:0];
        tone_en_d = (bus.wdata[3:0] != 4'hF);
      end
    end
    sticky_d = (sticky_q | btn_edge) & ~clr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      sticky_q  <= '0;
      hit_q     <= 1'b0;
      rd_q      <= '0;
      tone_q    <= 4'hF;
      tone_en_q <= 1'b0;
      target_q  <= '{default: '0};
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      sticky_q  <= sticky_d;
      hit_q     <= hit_d;
      rd_q      <= rd_d;
      tone_q    <= tone_d;
      tone_en_q <= tone_en_d;
      target_q  <= target_d;
    end
  end

`ifdef HUB_SLEW_EN
  localparam int                PW     = $clog2(SLEW_DIV);
  localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(SLEW_STEP);

  logic [PW-1:0]     presc_q;
  logic              tick;
  logic [DUTY_W-1:0] gap;
  logic [DUTY_W-1:0] duty_q [NUM_SERVO];
  logic [DUTY_W-1:0] duty_d [NUM_SERVO];

  assign tick = (presc_q == PW'(SLEW_DIV - 1));

  // Steps use the target registered before this edge, so a fresh write
  // retargets at the following tick.
  always_comb begin
    duty_d = duty_q;
    gap    = '0;
    if (tick) begin
      for (int i = 0; i < NUM_SERVO; i++) begin
        if (target_q[i] > duty_q[i]) begin
          gap       = target_q[i] - duty_q[i];
          duty_d[i] = duty_q[i] + ((32'(gap) > SLEW_STEP) ? STEP_V : gap);
        end else if (target_q[i] < duty_q[i]) begin
          gap       = duty_q[i] - target_q[i];
          duty_d[i] = duty_q[i] - ((32'(gap) > SLEW_STEP) ? STEP_V : gap);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      duty_q  <= '{default: '0};
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      duty_q  <= duty_d;
    end
  end

  assign duty_cur = duty_q;
`else
  logic unused_slew_cfg;
  assign unused_slew_cfg = ^{32'(SLEW_DIV), 32'(SLEW_STEP)};
  assign duty_cur = target_q;
`endif

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata;

  for (genvar g = 0; g < NUM_SERVO; g++) begin : g_duty
    assign duty[g*DUTY_W +: DUTY_W] = duty_cur[g];
  end

  assign bus.rdata = hit_q ? rd_q : bus.ram_q;
  assign tone      = tone_q;
  assign tone_en   = tone_en_q;

endmodule

// File: tb/tb_mmio_peripheral_hub.sv
// Bench for mmio_peripheral_hub: table of bus operations plus hand sequences for
// button edges, servo writes/slew and asynchronous reset.
module tb_mmio_peripheral_hub;
  localparam int          NUM_BTN   = 6;
  localparam int          NUM_SERVO = 3;
  localparam int          DUTY_W    = 10;
  localparam logic [11:0] IDLE_ADDR = 12'd5;
  localparam logic [31:0] RAM_VAL   = 32'hDEADBEEF;

  logic                        clock;
  logic                        reset;
  logic [NUM_BTN-1:0]          btn;
  logic [NUM_SERVO*DUTY_W-1:0] duty;
  logic [3:0]                  tone;
  logic                        tone_en;

  mmio_peripheral_hub_if bus ();

  mmio_peripheral_hub #(
    .NUM_BTN(NUM_BTN), .NUM_SERVO(NUM_SERVO), .DUTY_W(DUTY_W),
    .BTN_BASE(12'd64), .SERVO_BASE(12'd80), .TONE_ADDR(12'd96),
    .SLEW_DIV(4), .SLEW_STEP(3)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .btn(btn),
    .duty(duty), .tone(tone), .tone_en(tone_en)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] duty_ch(input int i);
    return 32'(duty[i*DUTY_W +: DUTY_W]);
  endfunction

  // driver: one bus cycle; expected rdata queued at drive, compared after the edge
  task automatic do_op(input logic [11:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] exp, input string name);
    logic [31:0] e;
    @(negedge clock);
    bus.addr  = a;
    bus.wren  = w;
    bus.wdata = d;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    bus.addr = IDLE_ADDR;
    bus.wren = 1'b0;
    e = exp_q.pop_front();
    check(name, bus.rdata, e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [11:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [3:0]  exp_tone;
    logic        exp_en;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int k;
    int cyc;
    int last;
    int changes;
    logic [31:0] prev;
    logic [31:0] seq_up [4];
    logic [31:0] seq_dn [2];

    vecs[0]  = '{12'd5,  1'b0, 32'h0,          RAM_VAL,      4'hF, 1'b0};
    vecs[1]  = '{12'd96, 1'b1, 32'h00000005,   32'h0000000F, 4'h5, 1'b1};
    vecs[2]  = '{12'd96, 1'b0, 32'h0,          32'h00000015, 4'h5, 1'b1};
    vecs[3]  = '{12'd96, 1'b1, 32'hFFFFFFFF,   32'h00000015, 4'hF, 1'b0};
    vecs[4]  = '{12'd96, 1'b0, 32'h0,          32'h0000000F, 4'hF, 1'b0};
    vecs[5]  = '{12'd96, 1'b1, 32'h1234561A,   32'h0000000F, 4'hA, 1'b1};
    vecs[6]  = '{12'd66, 1'b1, 32'h00000001,   32'h00000000, 4'hA, 1'b1};
    vecs[7]  = '{12'd97, 1'b0, 32'h0,          RAM_VAL,      4'hA, 1'b1};
    vecs[8]  = '{12'd63, 1'b0, 32'h0,          RAM_VAL,      4'hA, 1'b1};
    vecs[9]  = '{12'd70, 1'b0, 32'h0,          RAM_VAL,      4'hA, 1'b1};
    vecs[10] = '{12'd69, 1'b0, 32'h0,          32'h00000000, 4'hA, 1'b1};
    vecs[11] = '{12'd83, 1'b1, 32'h00000077,   RAM_VAL,      4'hA, 1'b1};
    seq_up = '{32'd3, 32'd6, 32'd9, 32'd10};
    seq_dn = '{32'd7, 32'd4};

    // reset state, rdata follows ram_q combinationally
    reset = 1'b0;
    btn = '0;
    bus.addr = IDLE_ADDR;
    bus.wren = 1'b0;
    bus.wdata = '0;
    bus.ram_q = RAM_VAL;
    cycles(3);
    check("rst_duty0", duty_ch(0), 32'd0);
    check("rst_duty2", duty_ch(2), 32'd0);
    check("rst_tone", 32'(tone), 32'hF);
    check("rst_tone_en", 32'(tone_en), 32'd0);
    check("rst_rdata", bus.rdata, RAM_VAL);
    bus.ram_q = 32'h12345678;
    #1;
    check("rst_rdata_pass", bus.rdata, 32'h12345678);
    bus.ram_q = RAM_VAL;
    @(negedge clock);
    reset = 1'b1;

    // table-driven bus operations
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].exp_rd, $sformatf("vec%0d_rdata", i));
      check($sformatf("vec%0d_tone", i), 32'(tone), 32'(vecs[i].exp_tone));
      check($sformatf("vec%0d_tone_en", i), 32'(tone_en), 32'(vecs[i].exp_en));
    end

    // button pulse, sticky read, clear-on-read, neighbour stays clear
    @(negedge clock);
    btn[2] = 1'b1;
    cycles(2);
    @(negedge clock);
    btn[2] = 1'b0;
    cycles(5);
    do_op(12'd66, 1'b0, 32'h0, 32'd1, "btn2_read");
    do_op(12'd66, 1'b0, 32'h0, 32'd0, "btn2_reread");
    do_op(12'd67, 1'b0, 32'h0, 32'd0, "btn3_read");

    // edge arriving on the read cycle is reported, then cleared
    @(negedge clock);
    btn[4] = 1'b1;
    @(posedge clock);
    @(posedge clock);
    do_op(12'd68, 1'b0, 32'h0, 32'd1, "btn4_coincident");
    do_op(12'd68, 1'b0, 32'h0, 32'd0, "btn4_after");
    btn[4] = 1'b0;

`ifdef HUB_SLEW_EN
    // slew: 0 -> 10 in steps of 3 every 4 cycles, then back down to 4
    do_op(12'd81, 1'b1, 32'd10, 32'd0, "servo1_wr10");
    prev = 0; k = 0; cyc = 0; last = 0;
    while (k < 4 && cyc < 60) begin
      cycles(1);
      cyc++;
      if (duty_ch(1) != prev) begin
        check($sformatf("slew_up%0d", k), duty_ch(1), seq_up[k]);
        if (k > 0) check($sformatf("slew_up_gap%0d", k), 32'(cyc - last), 32'd4);
        prev = duty_ch(1); last = cyc; k++;
      end
    end
    check("slew_up_done", 32'(k), 32'd4);
    changes = 0;
    for (int i = 0; i < 12; i++) begin
      cycles(1);
      if (duty_ch(1) != 32'd10) changes++;
    end
    check("slew_hold", 32'(changes), 32'd0);
    do_op(12'd81, 1'b1, 32'd4, 32'd10, "servo1_wr4");
    prev = 10; k = 0; cyc = 0;
    while (k < 2 && cyc < 40) begin
      cycles(1);
      cyc++;
      if (duty_ch(1) != prev) begin
        check($sformatf("slew_dn%0d", k), duty_ch(1), seq_dn[k]);
        prev = duty_ch(1); k++;
      end
    end
    check("slew_dn_done", 32'(k), 32'd2);
    check("slew_duty0", duty_ch(0), 32'd0);
    check("slew_duty2", duty_ch(2), 32'd0);
    do_op(12'd81, 1'b0, 32'h0, 32'd4, "servo1_read");
`else
    // direct duty: write visible next cycle, read returns current duty
    do_op(12'd80, 1'b1, 32'd500, 32'd0, "servo0_wr");
    check("servo0_duty", duty_ch(0), 32'd500);
    check("servo1_untouched", duty_ch(1), 32'd0);
    do_op(12'd80, 1'b0, 32'h0, 32'd500, "servo0_read");
    do_op(12'd82, 1'b1, 32'hFFFFFFFF, 32'd0, "servo2_wr");
    check("servo2_trunc", duty_ch(2), 32'd1023);
    do_op(12'd82, 1'b0, 32'h0, 32'd1023, "servo2_read");
    do_op(12'd81, 1'b1, 32'd7, 32'd0, "servo1_wr");
    check("servo1_duty", duty_ch(1), 32'd7);
    do_op(12'd100, 1'b0, 32'h0, RAM_VAL, "unmapped_read");
`endif

    // asynchronous reset mid-operation
    do_op(12'd96, 1'b1, 32'd3, 32'h0000001A, "tone_wr3");
    do_op(12'd64, 1'b0, 32'h0, 32'd0, "btn0_read");
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("arst_tone", 32'(tone), 32'hF);
    check("arst_tone_en", 32'(tone_en), 32'd0);
    check("arst_duty1", duty_ch(1), 32'd0);
    check("arst_rdata", bus.rdata, RAM_VAL);
    @(negedge clock);
    reset = 1'b1;
    do_op(12'd96, 1'b0, 32'h0, 32'h0000000F, "post_rst_tone_read");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
